// File: rtl/musa_pkg.sv
// musa_pkg: shared core constants (program counter width, call-stack overflow modes)
package musa_pkg;
   localparam int PC_W     = 18;
   localparam int OVF_DROP = 0;
   localparam int OVF_WRAP = 1;
endpackage

// File: rtl/call_stack_ram.sv
// call_stack_ram: DEPTH x W storage, synchronous write, asynchronous read, no reset
module call_stack_ram #(
   parameter int W     = 18,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [W-1:0]  wd,
   input  logic [AW-1:0] ra,
   output logic [W-1:0]  rd
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   assign rd = mem[ra];
endmodule

// File: rtl/call_stack.sv
// call_stack: LIFO of return addresses in a circular buffer with top pointer,
// occupancy counter and sticky overflow/underflow flags
module call_stack
   import musa_pkg::*;
#(
   parameter int ADDR_W   = PC_W,
   parameter int DEPTH    = 16,
   parameter int OVF_MODE = OVF_DROP
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [ADDR_W-1:0]          push_addr,
   input  logic                       clr_err,
   output logic [ADDR_W-1:0]          top_addr,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEPTH+1);
   localparam bit WRAP = (OVF_MODE == OVF_WRAP);
   logic [AW-1:0]     ptr, wr_idx;
   logic [ADDR_W-1:0] rd_data;
   logic              replace, adv, retract, ovf_set, unf_set;
   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign top_addr = empty ? '0 : rd_data;
   // push+pop on an empty stack degenerates to a plain push
   always_comb begin
      replace = push & pop & ~empty;
      adv     = (push & ~pop & (~full | WRAP)) | (push & pop & empty);
      retract = pop & ~push & ~empty;
      ovf_set = push & ~pop & full;
      unf_set = pop & empty;
      wr_idx  = replace ? ptr : ptr + AW'(1);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         ptr       <= adv ? ptr + AW'(1) : retract ? ptr - AW'(1) : ptr;
         count     <= (adv & ~full) ? count + CW'(1) : retract ? count - CW'(1) : count;
         overflow  <= ovf_set | (overflow & ~clr_err);
         underflow <= unf_set | (underflow & ~clr_err);
      end
   end
   call_stack_ram #(.W(ADDR_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk (clk),
      .we  (replace | adv),
      .wa  (wr_idx),
      .wd  (push_addr),
      .ra  (ptr),
      .rd  (rd_data)
   );
endmodule
